// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-lookup and commit signals of the reorder buffer.
// The master modport belongs to the core (decoder/RS/LSB/regfile side).
interface reorder_buffer_if #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 32
);
  logic              rob_full;
  logic [IDX_W-1:0]  rob_tail_idx_out;
  logic              de_in_en;
  logic [1:0]        de_type_in;
  logic [4:0]        de_rd_in;
  logic              de_pred_jump_in;
  logic [DATA_W-1:0] de_pc_in;
  logic [DATA_W-1:0] de_target_in;
  logic [IDX_W-1:0]  qj_idx_in;
  logic [IDX_W-1:0]  qk_idx_in;
  logic              qj_ready_out;
  logic              qk_ready_out;
  logic [DATA_W-1:0] qj_val_out;
  logic [DATA_W-1:0] qk_val_out;
  logic              rs2cdb_out_en;
  logic [IDX_W-1:0]  rs2cdb_rob_idx_out;
  logic [DATA_W-1:0] rs2cdb_val_out;
  logic              rs_jump_in;
  logic              lsb_in_en;
  logic [IDX_W-1:0]  lsb_rob_idx_in;
  logic [DATA_W-1:0] lsb_val_in;
  logic              commit_reg_en;
  logic [4:0]        commit_rd;
  logic [DATA_W-1:0] commit_val;
  logic [IDX_W-1:0]  commit_rob_idx;
  logic              commit_store_en;
  logic              roll_back;
  logic [DATA_W-1:0] roll_back_pc;

  modport master (
    input  rob_full, rob_tail_idx_out, qj_ready_out, qk_ready_out, qj_val_out, qk_val_out,
           commit_reg_en, commit_rd, commit_val, commit_rob_idx, commit_store_en,
           roll_back, roll_back_pc,
    output de_in_en, de_type_in, de_rd_in, de_pred_jump_in, de_pc_in, de_target_in,
           qj_idx_in, qk_idx_in, rs2cdb_out_en, rs2cdb_rob_idx_out, rs2cdb_val_out,
           rs_jump_in, lsb_in_en, lsb_rob_idx_in, lsb_val_in
  );

  modport slave (
    output rob_full, rob_tail_idx_out, qj_ready_out, qk_ready_out, qj_val_out, qk_val_out,
           commit_reg_en, commit_rd, commit_val, commit_rob_idx, commit_store_en,
           roll_back, roll_back_pc,
    input  de_in_en, de_type_in, de_rd_in, de_pred_jump_in, de_pc_in, de_target_in,
           qj_idx_in, qk_idx_in, rs2cdb_out_en, rs2cdb_rob_idx_out, rs2cdb_val_out,
           rs_jump_in, lsb_in_en, lsb_rob_idx_in, lsb_val_in
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates at tail, captures CDB results,
// retires one ready head entry per cycle and flushes on branch misprediction.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned DATA_W   = 32
) (
  input logic             clk,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave rob
);
  localparam int unsigned CntW = IDX_W + 1;
  localparam logic [1:0] TypeReg    = 2'd0;
  localparam logic [1:0] TypeStore  = 2'd1;
  localparam logic [1:0] TypeBranch = 2'd2;

  logic [ROB_SIZE-1:0] ready_q, jump_q, pred_q;
  logic [1:0]          type_q   [ROB_SIZE];
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [DATA_W-1:0]   pc_q     [ROB_SIZE];
  logic [DATA_W-1:0]   target_q [ROB_SIZE];
  logic [DATA_W-1:0]   val_q    [ROB_SIZE];
  logic [IDX_W-1:0]    head_q, tail_q;
  logic [CntW-1:0]     count_q;

  logic              commit_reg_en_q, commit_store_en_q, roll_back_q;
  logic [4:0]        commit_rd_q;
  logic [DATA_W-1:0] commit_val_q, roll_back_pc_q;
  logic [IDX_W-1:0]  commit_rob_idx_q;

  logic accept, disp_fire, rs_fire, lsb_fire, commit_fire, mispredict;

  assign rob.rob_full         = (count_q == CntW'(ROB_SIZE));
  assign rob.rob_tail_idx_out = tail_q;
  assign rob.commit_reg_en    = commit_reg_en_q;
  assign rob.commit_store_en  = commit_store_en_q;
  assign rob.commit_rd        = commit_rd_q;
  assign rob.commit_val       = commit_val_q;
  assign rob.commit_rob_idx   = commit_rob_idx_q;
  assign rob.roll_back        = roll_back_q;
  assign rob.roll_back_pc     = roll_back_pc_q;

  // New work is dropped during the flush cycle; commit needs count>0 so it idles too.
  assign accept      = rdy_in && !roll_back_q;
  assign disp_fire   = accept && rob.de_in_en && !rob.rob_full;
  assign rs_fire     = accept && rob.rs2cdb_out_en;
  assign lsb_fire    = accept && rob.lsb_in_en;
  assign commit_fire = rdy_in && (count_q != '0) && ready_q[head_q];
  assign mispredict  = commit_fire && (type_q[head_q] == TypeBranch) &&
                       (jump_q[head_q] != pred_q[head_q]);

  always_comb begin
    rob.qj_ready_out = ready_q[rob.qj_idx_in];
    rob.qj_val_out   = val_q[rob.qj_idx_in];
    if (rob.lsb_in_en && rob.lsb_rob_idx_in == rob.qj_idx_in) begin
      rob.qj_ready_out = 1'b1;
      rob.qj_val_out   = rob.lsb_val_in;
    end
    if (rob.rs2cdb_out_en && rob.rs2cdb_rob_idx_out == rob.qj_idx_in) begin
      rob.qj_ready_out = 1'b1;
      rob.qj_val_out   = rob.rs2cdb_val_out;
    end
  end

  always_comb begin
    rob.qk_ready_out = ready_q[rob.qk_idx_in];
    rob.qk_val_out   = val_q[rob.qk_idx_in];
    if (rob.lsb_in_en && rob.lsb_rob_idx_in == rob.qk_idx_in) begin
      rob.qk_ready_out = 1'b1;
      rob.qk_val_out   = rob.lsb_val_in;
    end
    if (rob.rs2cdb_out_en && rob.rs2cdb_rob_idx_out == rob.qk_idx_in) begin
      rob.qk_ready_out = 1'b1;
      rob.qk_val_out   = rob.rs2cdb_val_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      ready_q           <= '0;
      commit_reg_en_q   <= 1'b0;
      commit_store_en_q <= 1'b0;
      roll_back_q       <= 1'b0;
      commit_rd_q       <= '0;
      commit_val_q      <= '0;
      commit_rob_idx_q  <= '0;
      roll_back_pc_q    <= '0;
      for (int unsigned i = 0; i < ROB_SIZE; i++) val_q[i] <= '0;
    end else if (!rdy_in) begin
      commit_reg_en_q   <= 1'b0;
      commit_store_en_q <= 1'b0;
      roll_back_q       <= 1'b0;
    end else begin
      commit_reg_en_q   <= 1'b0;
      commit_store_en_q <= 1'b0;
      roll_back_q       <= 1'b0;
      if (rs_fire) begin
        val_q[rob.rs2cdb_rob_idx_out]   <= rob.rs2cdb_val_out;
        jump_q[rob.rs2cdb_rob_idx_out]  <= rob.rs_jump_in;
        ready_q[rob.rs2cdb_rob_idx_out] <= 1'b1;
      end
      if (lsb_fire) begin
        val_q[rob.lsb_rob_idx_in]   <= rob.lsb_val_in;
        ready_q[rob.lsb_rob_idx_in] <= 1'b1;
      end
      if (disp_fire) begin
        type_q[tail_q]   <= rob.de_type_in;
        rd_q[tail_q]     <= rob.de_rd_in;
        pred_q[tail_q]   <= rob.de_pred_jump_in;
        pc_q[tail_q]     <= rob.de_pc_in;
        target_q[tail_q] <= rob.de_target_in;
        ready_q[tail_q]  <= 1'b0;
      end
      if (commit_fire) begin
        commit_rob_idx_q <= head_q;
        commit_rd_q      <= rd_q[head_q];
        commit_val_q     <= val_q[head_q];
        case (type_q[head_q])
          TypeReg:    commit_reg_en_q   <= (rd_q[head_q] != 5'd0);
          TypeStore:  commit_store_en_q <= 1'b1;
          TypeBranch: begin
            if (mispredict) begin
              roll_back_q    <= 1'b1;
              roll_back_pc_q <= jump_q[head_q] ? target_q[head_q]
                                               : pc_q[head_q] + DATA_W'(4);
            end
          end
          default: ;
        endcase
      end
      if (mispredict) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_q + IDX_W'(commit_fire);
        tail_q  <= tail_q + IDX_W'(disp_fire);
        count_q <= count_q + CntW'(disp_fire) - CntW'(commit_fire);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, out-of-order capture, in-order
// commit, full/wrap, mispredict flush, bypass, stall and mid-stream reset.
module tb_reorder_buffer;
  localparam int unsigned IdxW  = 4;
  localparam int unsigned DataW = 32;

  logic clk;
  logic rst_in;
  logic rdy_in;
  int   tests;
  int   fails;

  reorder_buffer_if #(.IDX_W(IdxW), .DATA_W(DataW)) rob_if ();

  reorder_buffer #(.ROB_SIZE(16), .IDX_W(IdxW), .DATA_W(DataW)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rob    (rob_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rob_if.de_in_en           = 1'b0;
    rob_if.de_type_in         = 2'd0;
    rob_if.de_rd_in           = 5'd0;
    rob_if.de_pred_jump_in    = 1'b0;
    rob_if.de_pc_in           = '0;
    rob_if.de_target_in       = '0;
    rob_if.rs2cdb_out_en      = 1'b0;
    rob_if.rs2cdb_rob_idx_out = '0;
    rob_if.rs2cdb_val_out     = '0;
    rob_if.rs_jump_in         = 1'b0;
    rob_if.lsb_in_en          = 1'b0;
    rob_if.lsb_rob_idx_in     = '0;
    rob_if.lsb_val_in         = '0;
  endtask

  task automatic dispatch(input logic [1:0] ty, input logic [4:0] rd, input logic pred,
                          input logic [31:0] pc, input logic [31:0] tgt);
    rob_if.de_in_en        = 1'b1;
    rob_if.de_type_in      = ty;
    rob_if.de_rd_in        = rd;
    rob_if.de_pred_jump_in = pred;
    rob_if.de_pc_in        = pc;
    rob_if.de_target_in    = tgt;
    step();
    rob_if.de_in_en = 1'b0;
  endtask

  task automatic rs_result(input logic [3:0] idx, input logic [31:0] val, input logic jmp);
    rob_if.rs2cdb_out_en      = 1'b1;
    rob_if.rs2cdb_rob_idx_out = idx;
    rob_if.rs2cdb_val_out     = val;
    rob_if.rs_jump_in         = jmp;
    step();
    rob_if.rs2cdb_out_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rdy_in = 1'b1;
    rob_if.qj_idx_in = '0;
    rob_if.qk_idx_in = '0;
    clear_inputs();
    rst_in = 1'b0;
    step();
    step();
    rst_in = 1'b1;

    chk("reset_full", rob_if.rob_full, 0);
    chk("reset_tail", rob_if.rob_tail_idx_out, 0);
    chk("reset_reg_en", rob_if.commit_reg_en, 0);
    chk("reset_store_en", rob_if.commit_store_en, 0);
    chk("reset_roll_back", rob_if.roll_back, 0);
    chk("reset_qj_ready", rob_if.qj_ready_out, 0);

    // Three REG entries, results arrive 2,0,1; commits must be in order
    dispatch(2'd0, 5'd1, 1'b0, 32'h0, 32'h0);
    dispatch(2'd0, 5'd2, 1'b0, 32'h4, 32'h0);
    dispatch(2'd0, 5'd3, 1'b0, 32'h8, 32'h0);
    chk("tail_after_3", rob_if.rob_tail_idx_out, 3);
    rs_result(4'd2, 32'h30, 1'b0);
    chk("no_commit_head_busy", rob_if.commit_reg_en, 0);
    rob_if.qj_idx_in = 4'd2;
    #1;
    chk("stored_qj_ready", rob_if.qj_ready_out, 1);
    chk("stored_qj_val", rob_if.qj_val_out, 32'h30);
    rs_result(4'd0, 32'h10, 1'b0);
    chk("no_commit_same_edge", rob_if.commit_reg_en, 0);
    rs_result(4'd1, 32'h20, 1'b0);
    chk("c0_en", rob_if.commit_reg_en, 1);
    chk("c0_rd", rob_if.commit_rd, 1);
    chk("c0_val", rob_if.commit_val, 32'h10);
    chk("c0_idx", rob_if.commit_rob_idx, 0);
    step();
    chk("c1_rd", rob_if.commit_rd, 2);
    chk("c1_val", rob_if.commit_val, 32'h20);
    step();
    chk("c2_rd", rob_if.commit_rd, 3);
    chk("c2_val", rob_if.commit_val, 32'h30);
    step();
    chk("empty_no_commit", rob_if.commit_reg_en, 0);

    // Fill all 16 slots, 17th dispatch ignored, commit frees one slot
    do_reset();
    for (int i = 0; i < 16; i++) dispatch(2'd0, 5'(i + 1), 1'b0, 32'h0, 32'h0);
    chk("full_after_16", rob_if.rob_full, 1);
    chk("tail_wrapped", rob_if.rob_tail_idx_out, 0);
    dispatch(2'd0, 5'd31, 1'b0, 32'h0, 32'h0);
    chk("17th_ignored_tail", rob_if.rob_tail_idx_out, 0);
    chk("17th_ignored_full", rob_if.rob_full, 1);
    rs_result(4'd0, 32'h55, 1'b0);
    chk("full_before_commit", rob_if.rob_full, 1);
    step();
    chk("full_commit_en", rob_if.commit_reg_en, 1);
    chk("full_commit_rd", rob_if.commit_rd, 1);
    chk("full_commit_val", rob_if.commit_val, 32'h55);
    chk("full_dropped", rob_if.rob_full, 0);

    // Mispredicted branch (pred 0, taken) flushes a ready younger REG entry
    do_reset();
    dispatch(2'd2, 5'd0, 1'b0, 32'h100, 32'h200);
    dispatch(2'd0, 5'd9, 1'b0, 32'h104, 32'h0);
    rs_result(4'd1, 32'h99, 1'b0);
    rs_result(4'd0, 32'h0, 1'b1);
    step();
    chk("mp_roll_back", rob_if.roll_back, 1);
    chk("mp_pc", rob_if.roll_back_pc, 32'h200);
    chk("mp_idx", rob_if.commit_rob_idx, 0);
    chk("mp_no_reg", rob_if.commit_reg_en, 0);
    chk("mp_tail_zero", rob_if.rob_tail_idx_out, 0);
    rob_if.rs2cdb_out_en      = 1'b1;
    rob_if.rs2cdb_rob_idx_out = 4'd0;
    rob_if.rs2cdb_val_out     = 32'h1;
    dispatch(2'd0, 5'd4, 1'b0, 32'h0, 32'h0);
    rob_if.rs2cdb_out_en = 1'b0;
    chk("mp_pulse_done", rob_if.roll_back, 0);
    chk("mp_dispatch_ignored", rob_if.rob_tail_idx_out, 0);
    chk("mp_young_flushed", rob_if.commit_reg_en, 0);
    step();
    chk("mp_young_flushed2", rob_if.commit_reg_en, 0);
    dispatch(2'd0, 5'd4, 1'b0, 32'h0, 32'h0);
    chk("mp_dispatch_after", rob_if.rob_tail_idx_out, 1);

    // Predicted taken: correct when taken, pc+4 redirect when not taken
    do_reset();
    dispatch(2'd2, 5'd0, 1'b1, 32'h100, 32'h200);
    dispatch(2'd2, 5'd0, 1'b1, 32'h100, 32'h200);
    rs_result(4'd0, 32'h0, 1'b1);
    rs_result(4'd1, 32'h0, 1'b0);
    chk("bt_no_roll_back", rob_if.roll_back, 0);
    chk("bt_idx", rob_if.commit_rob_idx, 0);
    step();
    chk("bnt_roll_back", rob_if.roll_back, 1);
    chk("bnt_pc", rob_if.roll_back_pc, 32'h104);
    chk("bnt_idx", rob_if.commit_rob_idx, 1);
    step();
    chk("bnt_pulse_done", rob_if.roll_back, 0);

    // Same-cycle bypass on both lookup ports
    rob_if.qj_idx_in          = 4'd5;
    rob_if.rs2cdb_out_en      = 1'b1;
    rob_if.rs2cdb_rob_idx_out = 4'd5;
    rob_if.rs2cdb_val_out     = 32'hDEAD;
    rob_if.qk_idx_in          = 4'd6;
    rob_if.lsb_in_en          = 1'b1;
    rob_if.lsb_rob_idx_in     = 4'd6;
    rob_if.lsb_val_in         = 32'hBEEF;
    #1;
    chk("byp_qj_ready", rob_if.qj_ready_out, 1);
    chk("byp_qj_val", rob_if.qj_val_out, 32'hDEAD);
    chk("byp_qk_ready", rob_if.qk_ready_out, 1);
    chk("byp_qk_val", rob_if.qk_val_out, 32'hBEEF);
    clear_inputs();
    #1;
    chk("nobyp_qk_ready", rob_if.qk_ready_out, 0);

    // REG rd=0 suppresses the regfile write; STORE releases to the LSB
    dispatch(2'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    dispatch(2'd1, 5'd0, 1'b0, 32'h4, 32'h0);
    rob_if.rs2cdb_out_en      = 1'b1;
    rob_if.rs2cdb_rob_idx_out = 4'd0;
    rob_if.rs2cdb_val_out     = 32'h77;
    rob_if.lsb_in_en          = 1'b1;
    rob_if.lsb_rob_idx_in     = 4'd1;
    rob_if.lsb_val_in         = 32'h1000;
    step();
    clear_inputs();
    step();
    chk("rd0_no_reg_en", rob_if.commit_reg_en, 0);
    chk("rd0_idx", rob_if.commit_rob_idx, 0);
    chk("rd0_val", rob_if.commit_val, 32'h77);
    step();
    chk("store_en", rob_if.commit_store_en, 1);
    chk("store_idx", rob_if.commit_rob_idx, 1);
    chk("store_no_reg_en", rob_if.commit_reg_en, 0);
    step();
    chk("store_pulse_done", rob_if.commit_store_en, 0);

    // Stall for three cycles with a ready head, then release
    for (int i = 0; i < 5; i++) dispatch(2'd0, 5'(11 + i), 1'b0, 32'h0, 32'h0);
    chk("stall_tail_before", rob_if.rob_tail_idx_out, 7);
    rs_result(4'd2, 32'hA2, 1'b0);
    rdy_in = 1'b0;
    rob_if.de_in_en   = 1'b1;
    rob_if.de_type_in = 2'd0;
    rob_if.de_rd_in   = 5'd20;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_commit", rob_if.commit_reg_en, 0);
    end
    chk("stall_tail_held", rob_if.rob_tail_idx_out, 7);
    rob_if.de_in_en = 1'b0;
    rdy_in = 1'b1;
    step();
    chk("resume_commit_en", rob_if.commit_reg_en, 1);
    chk("resume_commit_rd", rob_if.commit_rd, 11);
    chk("resume_commit_val", rob_if.commit_val, 32'hA2);
    dispatch(2'd0, 5'd21, 1'b0, 32'h0, 32'h0);
    chk("five_entries_tail", rob_if.rob_tail_idx_out, 8);

    // Reset mid-stream with five live entries
    rob_if.qj_idx_in = 4'd2;
    do_reset();
    chk("mrst_tail", rob_if.rob_tail_idx_out, 0);
    chk("mrst_reg_en", rob_if.commit_reg_en, 0);
    chk("mrst_rd", rob_if.commit_rd, 0);
    chk("mrst_val", rob_if.commit_val, 0);
    chk("mrst_rob_idx", rob_if.commit_rob_idx, 0);
    chk("mrst_rb_pc", rob_if.roll_back_pc, 0);
    chk("mrst_qj_ready", rob_if.qj_ready_out, 0);
    chk("mrst_qj_val", rob_if.qj_val_out, 0);
    step();
    chk("mrst_no_commit", rob_if.commit_reg_en, 0);
    dispatch(2'd0, 5'd1, 1'b0, 32'h0, 32'h0);
    chk("mrst_tail_restart", rob_if.rob_tail_idx_out, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer for the Tomasulo core; the consuming end of the CDB that the reservation station and LSB drive.
- Allocates a ROB index per dispatched instruction and captures results broadcast by RS and LSB.
- Retires one entry per cycle in program order: register writes go to the regfile; stores are released to the LSB.
- Detects branch mispredictions at commit and drives roll_back.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
IDX_W, 4, log2(ROB_SIZE), width of ROB index
DATA_W, 32, data/PC width

Ports:
clk  in  1  system clock
rst_in  in  1  reset; one clock, reset is synchronous and active-low
rdy_in  in  1  ready; when low, pause (no state change)
rob_full  out  1  count == ROB_SIZE (combinational)
rob_tail_idx_out  out  IDX_W  index the next dispatched entry receives
de_in_en  in  1  dispatch valid
de_type_in  in  2  0=REG, 1=STORE, 2=BRANCH
de_rd_in  in  5  destination register (REG only)
de_pred_jump_in  in  1  predicted taken (BRANCH only)
de_pc_in  in  DATA_W  instruction PC
de_target_in  in  DATA_W  branch taken target
qj_idx_in / qk_idx_in  in  IDX_W  operand lookup indices
qj_ready_out / qk_ready_out  out  1  entry result available
qj_val_out / qk_val_out  out  DATA_W  entry result
rs2cdb_out_en  in  1  RS result valid
rs2cdb_rob_idx_out  in  IDX_W  RS result index
rs2cdb_val_out  in  DATA_W  RS result value
rs_jump_in  in  1  branch outcome (with RS result)
lsb_in_en  in  1  LSB result valid (load data / store address resolved)
lsb_rob_idx_in  in  IDX_W  LSB result index
lsb_val_in  in  DATA_W  LSB result value
commit_reg_en  out  1  pulse: write regfile
commit_rd  out  5  register
commit_val  out  DATA_W  value
commit_rob_idx  out  IDX_W  index retired (regfile clears dependence if matching)
commit_store_en  out  1  pulse: LSB may perform store commit_rob_idx
roll_back  out  1  pulse: misprediction flush
roll_back_pc  out  DATA_W  redirect PC

Behaviour:
- Reset (rst_in==0 at posedge):
  - head, tail and count are set to 0; all ready bits are cleared.
  - All pulse outputs, commit_rd, commit_val, commit_rob_idx and roll_back_pc are set to 0.
- rdy_in low: head, tail, count and entries hold; pulse outputs go to 0 at that edge.
- Dispatch:
  - On de_in_en with !rob_full, the entry at tail is written with ready=0, and tail becomes tail+1 mod ROB_SIZE.
  - de_in_en while rob_full is ignored; the decoder must not do this.
- Result capture:
  - rs2cdb_out_en writes val and jump into the entry and sets ready.
  - lsb_in_en writes val and sets ready.
  - Both may arrive in the same cycle at different indices; same-index collision is illegal.
  - Ready is visible the cycle after the capture edge.
- Lookup (combinational):
  - If qX_idx_in matches this cycle's rs2cdb or lsb index, the bypass value is returned with ready=1.
  - Otherwise the stored ready and val are returned.
- Commit:
  - At a posedge with count>0 and head ready, the head retires and head increments.
  - Outputs are registered, one cycle wide.
  - REG: commit_reg_en=1 only if rd!=0; commit_rob_idx is always driven.
  - STORE: commit_store_en=1.
  - BRANCH: no regfile write. If jump != pred: roll_back=1 and roll_back_pc = jump ? target : pc+4.
- Latency: a CDB result at edge E makes the head ready; that entry commits at edge E+1, and its outputs are visible after E+1.
- Count: dispatch and commit in the same cycle leave count unchanged; a full buffer with a commit frees one slot next cycle.
- Misprediction flush:
  - In the same edge that asserts roll_back, head, tail and count are set to 0.
  - In the cycle roll_back is high, de_in_en and CDB inputs are ignored.
- Wrap-around: indices wrap modulo ROB_SIZE; rob_full is derived from count, never from a head==tail compare.

Test Plan:
- Reset then dispatch 3 REG (rd=1,2,3): rob_tail_idx_out 0→3. CDB results arrive out of order (idx2=0x30, idx0=0x10, idx1=0x20). Commits occur in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles.
- Dispatch 16 entries: rob_full=1 and a 17th de_in_en is ignored. Resolving and committing head drops rob_full the cycle after commit; tail wraps to 0.
- BRANCH pc=0x100, target=0x200, pred=0, rs_jump_in=1: roll_back=1 with roll_back_pc=0x200; count=0 next cycle, and a younger REG entry never commits.
- BRANCH pred=1, jump=1: no roll_back. Same branch with pred=1, jump=0: roll_back_pc=0x104.
- qj_idx_in=5 while rs2cdb_out_en with idx5=0xDEAD in the same cycle: qj_ready_out=1 and qj_val_out=0xDEAD combinationally. REG rd=0 commits with commit_reg_en=0; STORE commits with commit_store_en=1.
- rst_in=0 mid-stream with 5 entries: all outputs 0 next cycle, and tail restarts at 0. rdy_in=0 for 3 cycles: no commit, and state is held.
